// File: rtl/matrix_transpose_pkg.sv
// ============================================================================
// Module  : matrix_transpose_pkg
// Brief   : Shared types, sizes and address helper for matrix_transpose_stream.
//           Optional feature macro: MTS_ADDR_GEN_EN (per-tile address fields).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package matrix_transpose_pkg;

    localparam int MTS_DATA_WIDTH = 64;
    localparam int MTS_TILE       = 8;
    localparam int MTS_ARR_SIZE   = 64;
    localparam int MTS_ADDR_WIDTH = 64;
    localparam int MTS_CNT_W      = $clog2(MTS_TILE);
    localparam int MTS_CHUNK_W    = $clog2(MTS_ARR_SIZE / MTS_TILE);

    typedef logic                   mts_sel_t;
    typedef logic [MTS_CNT_W-1:0]   mts_cnt_t;
    typedef logic [MTS_CHUNK_W-1:0] mts_chunk_t;

    // Per-bank tile descriptor; address fields exist only with address generation.
    typedef struct packed {
        logic                      mode;
`ifdef MTS_ADDR_GEN_EN
        logic [MTS_ADDR_WIDTH-1:0] base;
        mts_chunk_t                dr;
        mts_chunk_t                dc;
`endif
    } mts_desc_t;

    // Byte offset of element 0 of destination row: ((dr*tile+row)*arr + dc*tile)*bytes.
    function automatic logic [MTS_ADDR_WIDTH-1:0] mts_addr_offset(
        input logic [MTS_ADDR_WIDTH-1:0] dr,
        input logic [MTS_ADDR_WIDTH-1:0] dc,
        input logic [MTS_ADDR_WIDTH-1:0] row,
        input logic [MTS_ADDR_WIDTH-1:0] tile,
        input logic [MTS_ADDR_WIDTH-1:0] arr,
        input logic [MTS_ADDR_WIDTH-1:0] elem_bytes
    );
        logic [MTS_ADDR_WIDTH-1:0] w_row_idx;
        logic [MTS_ADDR_WIDTH-1:0] w_elem_idx;
        w_row_idx  = dr * tile + row;
        w_elem_idx = w_row_idx * arr + dc * tile;
        return w_elem_idx * elem_bytes;
    endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_transpose_stream_bank.sv
// ============================================================================
// Module  : mts_tile_bank
// Brief   : One TILE x TILE storage bank: row write port, row/column read mux.
//           Optional feature macro: MTS_ADDR_GEN_EN (not used in this file).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mts_tile_bank
    import matrix_transpose_pkg::*;
#(
    parameter int DATA_WIDTH = MTS_DATA_WIDTH,
    parameter int TILE       = MTS_TILE
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  mts_cnt_t              i_wr_idx,
    input  logic [DATA_WIDTH-1:0] i_wr_row [0:TILE-1],
    input  mts_cnt_t              i_rd_idx,
    input  logic                  i_transpose,
    output logic [DATA_WIDTH-1:0] o_rd_row [0:TILE-1]
);

    logic [DATA_WIDTH-1:0] r_mem [0:TILE-1][0:TILE-1];

    // Store an accepted input row; tile data is intentionally not reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int j = 0; j < TILE; j++) begin
                r_mem[i_wr_idx][j] <= i_wr_row[j];
            end
        end
    end

    // Read a column (transpose) or a row (pass-through) of the stored tile.
    always_comb begin
        for (int j = 0; j < TILE; j++) begin
            o_rd_row[j] = i_transpose ? r_mem[j][i_rd_idx] : r_mem[i_rd_idx][j];
        end
    end

endmodule

`default_nettype wire

// File: rtl/matrix_transpose_stream.sv
// ============================================================================
// Module  : matrix_transpose_stream
// Brief   : Double-buffered streaming tile transposer with valid/ready on both
//           sides and per-row store address generation.
//           Optional feature macro: MTS_ADDR_GEN_EN (enables out_addr; when
//           undefined out_addr is tied to 0).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_transpose_stream
    import matrix_transpose_pkg::*;
#(
    parameter int DATA_WIDTH = MTS_DATA_WIDTH,
    parameter int TILE       = MTS_TILE,
    parameter int ARR_SIZE   = MTS_ARR_SIZE,
    parameter int ADDR_WIDTH = MTS_ADDR_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cfg_transpose,
    input  logic [ADDR_WIDTH-1:0]              base_addr,
    input  logic [$clog2(ARR_SIZE/TILE)-1:0]   chunk_row,
    input  logic [$clog2(ARR_SIZE/TILE)-1:0]   chunk_col,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_WIDTH-1:0]              in_row [0:TILE-1],
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_WIDTH-1:0]              out_row [0:TILE-1],
    output logic                               out_last,
    output logic [ADDR_WIDTH-1:0]              out_addr
);

    localparam mts_cnt_t c_last_row = mts_cnt_t'(TILE - 1);

    logic [1:0]            r_full;
    mts_sel_t              r_wr_sel;
    mts_sel_t              r_rd_sel;
    mts_cnt_t              r_wr_cnt;
    mts_cnt_t              r_rd_cnt;
    mts_desc_t             r_desc [0:1];

    logic                  w_in_fire;
    logic                  w_out_fire;
    mts_desc_t             w_new_desc;
    logic [DATA_WIDTH-1:0] w_bank_row [0:1][0:TILE-1];

    assign in_ready   = !r_full[r_wr_sel];
    assign out_valid  = r_full[r_rd_sel];
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign out_last   = out_valid && (r_rd_cnt == c_last_row);

    // Descriptor captured on the first beat; destination swaps coords when transposing.
    always_comb begin
        w_new_desc      = '0;
        w_new_desc.mode = cfg_transpose;
`ifdef MTS_ADDR_GEN_EN
        w_new_desc.base = MTS_ADDR_WIDTH'(base_addr);
        w_new_desc.dr   = cfg_transpose ? mts_chunk_t'(chunk_col) : mts_chunk_t'(chunk_row);
        w_new_desc.dc   = cfg_transpose ? mts_chunk_t'(chunk_row) : mts_chunk_t'(chunk_col);
`endif
    end

    // Write-side row counter and bank select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt <= '0;
            r_wr_sel <= 1'b0;
        end else if (w_in_fire) begin
            if (r_wr_cnt == c_last_row) begin
                r_wr_cnt <= '0;
                r_wr_sel <= ~r_wr_sel;
            end else begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
        end
    end

    // Read-side row counter and bank select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_cnt <= '0;
            r_rd_sel <= 1'b0;
        end else if (w_out_fire) begin
            if (r_rd_cnt == c_last_row) begin
                r_rd_cnt <= '0;
                r_rd_sel <= ~r_rd_sel;
            end else begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
        end
    end

    // Bank full flags; a filling bank is never full, so set and clear never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 2'b00;
        end else begin
            if (w_in_fire && (r_wr_cnt == c_last_row)) begin
                r_full[r_wr_sel] <= 1'b1;
            end
            if (w_out_fire && (r_rd_cnt == c_last_row)) begin
                r_full[r_rd_sel] <= 1'b0;
            end
        end
    end

    // Latch the tile descriptor into the bank being filled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_desc[0] <= '0;
            r_desc[1] <= '0;
        end else if (w_in_fire && (r_wr_cnt == '0)) begin
            r_desc[r_wr_sel] <= w_new_desc;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        mts_tile_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .TILE       (TILE)
        ) u_bank (
            .clk         (clk),
            .i_wr_en     (w_in_fire && (r_wr_sel == mts_sel_t'(b))),
            .i_wr_idx    (r_wr_cnt),
            .i_wr_row    (in_row),
            .i_rd_idx    (r_rd_cnt),
            .i_transpose (r_desc[b].mode),
            .o_rd_row    (w_bank_row[b])
        );
    end

    // Drive the selected bank's row, forced to zero while no row is offered.
    always_comb begin
        for (int j = 0; j < TILE; j++) begin
            out_row[j] = out_valid ? w_bank_row[r_rd_sel][j] : '0;
        end
    end

`ifdef MTS_ADDR_GEN_EN
    // Byte address of element 0 of the outgoing row, modulo 2^ADDR_WIDTH.
    always_comb begin
        out_addr = '0;
        if (out_valid) begin
            out_addr = ADDR_WIDTH'(r_desc[r_rd_sel].base + mts_addr_offset(
                MTS_ADDR_WIDTH'(r_desc[r_rd_sel].dr),
                MTS_ADDR_WIDTH'(r_desc[r_rd_sel].dc),
                MTS_ADDR_WIDTH'(r_rd_cnt),
                MTS_ADDR_WIDTH'(TILE),
                MTS_ADDR_WIDTH'(ARR_SIZE),
                MTS_ADDR_WIDTH'(DATA_WIDTH / 8)));
        end
    end
`else
    logic w_unused_addr_inputs;
    assign w_unused_addr_inputs = ^{base_addr, chunk_row, chunk_col};
    assign out_addr = '0;
`endif

endmodule

`default_nettype wire

// File: doc/matrix_transpose_stream.md
# matrix_transpose_stream

Streaming, double-buffered tile transposer: accepts a TILE×TILE tile one row per beat over a valid/ready handshake and emits it as rows of the transpose (or unchanged) with a per-row store address. Two ping-pong banks let a new tile be filled while the previous one drains, for full-rate throughput with backpressure. It is the successor to the fixed-size, no-backpressure transpose top and feeds the memory store path of the HE pipeline.

## Interface
- DATA_WIDTH, 64, element width in bits
- TILE, 8, tile height and width in elements; row beat = TILE elements; power of two ≥2
- ARR_SIZE, 64, full matrix width/height in elements; multiple of TILE
- ADDR_WIDTH, 64, byte-address width
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- cfg_transpose  in  1  1 = transpose tile, 0 = pass-through; sampled on first beat of each tile
- base_addr  in  ADDR_WIDTH  matrix base byte address; sampled on first beat of each tile
- chunk_row, chunk_col  in  $clog2(ARR_SIZE/TILE) each  source tile coordinates; sampled on first beat
- in_valid  in  1  input row valid
- in_ready  out  1  input row accepted when in_valid && in_ready
- in_row  in  TILE×DATA_WIDTH (unpacked [0:TILE-1])  input row
- out_valid  out  1  output row valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_row  out  TILE×DATA_WIDTH  output row
- out_last  out  1  final row (row TILE-1) of a tile
- out_addr  out  ADDR_WIDTH  byte store address of out_row element 0

## Operation
- Two banks B0/B1, each TILE×TILE elements, full flag and latched tile descriptor (mode, base, destination tile coords).
- Write side: wr_sel (starts B0), wr_cnt 0..TILE-1. Accepted beat writes in_row to row wr_cnt of bank wr_sel; beat 0 also latches descriptor. Beat TILE-1 sets full[wr_sel], clears wr_cnt, toggles wr_sel.
- in_ready = !full[wr_sel].
- Read side: rd_sel (starts B0), rd_cnt 0..TILE-1. out_valid = full[rd_sel].
- out_row[j] = bank[rd_sel][j][rd_cnt] when transposing, bank[rd_sel][rd_cnt][j] otherwise.
- out_last = out_valid && rd_cnt == TILE-1.
- Accepted output beat increments rd_cnt; on last beat it clears full[rd_sel], clears rd_cnt, toggles rd_sel.
- Destination tile: (dr,dc) = (chunk_col,chunk_row) when transposing, else (chunk_row,chunk_col).
- out_addr = base + ((dr·TILE + rd_cnt)·ARR_SIZE + dc·TILE)·(DATA_WIDTH/8), computed modulo 2^ADDR_WIDTH; products zero-extended to ADDR_WIDTH.
- Simultaneous write-completion on one bank and read-completion on the other in the same cycle: both take effect; no conflict, since a bank is never written while full.
- Each bank follows EMPTY → FILLING (first beat accepted) → FULL (last beat) → DRAINING (first output accepted) → EMPTY (last output). The bank flags are the only state needed.
- out_row, out_addr, out_last are undefined-but-stable-to-X-free (0-data) when out_valid=0; consumers ignore them.

## Timing
- Reset (rst_n low, asynchronous): full flags, wr_sel, rd_sel, wr_cnt, rd_cnt, descriptors → 0; out_valid=0, out_last=0, out_addr=0, in_ready=1. Bank data is not reset.
- Reset mid-tile discards all partial and buffered tiles; first beat after release starts a new tile in B0.
- Latency: last input beat accepted in cycle t → out_valid=1 in cycle t+1.
- Throughput: with out_ready held 1, one row in and one row out per cycle sustained; no bubbles between tiles.
- Backpressure: with out_ready=0, at most two tiles buffered; the third tile's first beat sees in_ready=0.
- out_row, out_addr, out_last are held stable while out_valid && !out_ready.

## Configuration
- MTS_ADDR_GEN_EN defined: out_addr is computed as above, and base_addr/chunk_row/chunk_col are latched.
- MTS_ADDR_GEN_EN undefined: address logic and descriptor address fields are removed, and out_addr is tied to 0. Data path and handshake are unchanged.

## Structure
- Package matrix_transpose_pkg holds the bank-select/count typedefs sized from TILE, the descriptor struct (mode, base, dr, dc), and the address-offset function.
- One sub-module: mts_tile_bank. It holds one TILE×TILE storage bank with row-write port and row/column read mux selected by mode. The top instantiates two of them and holds the control counters and address math.

## Test plan
- Single tile, TILE=8, cfg_transpose=1, in_row[j]=16·r+j, out_ready=1. Required: out_row[j] for rd_cnt=k equals 16·j+k; out_valid rises 1 cycle after beat 7; out_last on 8th beat.
- Address: base=0x1000, ARR_SIZE=64, DATA_WIDTH=64, chunk (1,2), transpose. Row 0 out_addr = 0x1000+((16)·64+8)·8 = 0x3040; each later row is +0x200.
- Pass-through, cfg_transpose=0. Required: out_row equals in_row per beat, and addresses use (chunk_row,chunk_col).
- Backpressure: out_ready=0, stream 3 tiles. Required: in_ready drops after 16 accepted beats. Releasing out_ready drains tiles in order with stable outputs during stalls.
- Back-to-back: 4 tiles with alternating modes, out_ready=1. Required: 32 consecutive out_valid cycles with correct per-tile mode.
- Reset: assert rst_n low after beat 5 of tile 2. Required: immediately out_valid=0 and in_ready=1; a fresh tile afterwards transposes correctly from B0.
